id_scoreboard: RTL and testbench

Parametrised register scoreboard for the decode stage. It replaces single-entry load-use compare logic with per-register pending-write counters, so decode can stall correctly when any number of multi-cycle producers (loads, multiply/divide, long-latency memory) are in flight. It sits beside the register file in the decode stage:

- Decode presents an instruction's source and destination registers on the issue side.
- Write-back reports each retired register write on the completion side.

---
 rtl/id_scoreboard.sv | 98 +++++++++
 tb/tb_id_scoreboard.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/id_scoreboard.sv
// Per-register pending-write scoreboard for decode: counts in-flight writes, stalls issue on RAW or counter saturation.
// issue_ready is combinational; counters, pend_total and err update one cycle after the issue/wb that changes them.
module id_scoreboard #(
  parameter int REG_AW    = 5,
  parameter int NUM_SRC   = 2,
  parameter int CNT_W     = 2,
  parameter int WB_BYPASS = 1
) (
  input  logic                        clk,
  input  logic                        resetn,
  input  logic                        issue_valid,
  output logic                        issue_ready,
  input  logic                        issue_we,
  input  logic [REG_AW-1:0]           issue_dest,
  input  logic [NUM_SRC*REG_AW-1:0]   issue_src,
  input  logic [NUM_SRC-1:0]          issue_src_used,
  input  logic                        wb_valid,
  input  logic [REG_AW-1:0]           wb_dest,
  input  logic                        flush,
  output logic [(1<<REG_AW)-1:0]      busy_vec,
  output logic [REG_AW+CNT_W-1:0]     pend_total,
  output logic                        err
);

  localparam int NREG = 1 << REG_AW;
  localparam logic [CNT_W-1:0] CMAX = '1;

  logic [CNT_W-1:0]        w_cnt [NREG];
  logic [NUM_SRC-1:0]      w_src_haz;
  logic                    w_bypass;
  logic                    w_wb_nz;
  logic                    w_dec;
  logic                    w_uflow;
  logic                    w_sat;
  logic                    w_inc;
  logic [REG_AW+CNT_W-1:0] r_pend_total;
  logic                    r_err;

  assign w_bypass = (WB_BYPASS != 0);
  assign w_wb_nz  = wb_valid & (wb_dest != '0);
  assign w_dec    = w_wb_nz & (w_cnt[wb_dest] != '0);
  assign w_uflow  = w_wb_nz & (w_cnt[wb_dest] == '0);
  // Saturation deliberately ignores the same-cycle wb credit so a counter can never wrap.
  assign w_sat    = issue_we & (issue_dest != '0) & (w_cnt[issue_dest] == CMAX);

  for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
    logic [REG_AW-1:0] w_s;
    logic [CNT_W-1:0]  w_c;
    logic [CNT_W-1:0]  w_eff;
    logic              w_credit;
    assign w_s      = issue_src[i*REG_AW +: REG_AW];
    assign w_c      = w_cnt[w_s];
    assign w_credit = w_bypass & wb_valid & (wb_dest == w_s) & (w_c != '0);
    assign w_eff    = w_c - CNT_W'(w_credit);
    assign w_src_haz[i] = issue_src_used[i] & (w_s != '0) & (w_eff != '0);
  end

  assign issue_ready = ~flush & ~(|w_src_haz) & ~w_sat;
  assign w_inc       = issue_valid & issue_ready & issue_we & (issue_dest != '0);

  for (genvar g = 0; g < NREG; g++) begin : g_reg
    if (g == 0) begin : g_zero
      assign w_cnt[g]    = '0;
      assign busy_vec[g] = 1'b0;
    end else begin : g_cnt
      logic [CNT_W-1:0] r_cnt;
      logic             w_inc_g;
      logic             w_dec_g;
      assign w_inc_g = w_inc & (issue_dest == REG_AW'(g));
      assign w_dec_g = w_dec & (wb_dest == REG_AW'(g));
      always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)                r_cnt <= '0;
        else if (flush)             r_cnt <= '0;
        else if (w_inc_g & ~w_dec_g) r_cnt <= r_cnt + CNT_W'(1);
        else if (w_dec_g & ~w_inc_g) r_cnt <= r_cnt - CNT_W'(1);
      end
      assign w_cnt[g]    = r_cnt;
      assign busy_vec[g] = |r_cnt;
    end
  end

  // An inc and a dec cancel in the total whether or not they hit the same register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)             r_pend_total <= '0;
    else if (flush)          r_pend_total <= '0;
    else if (w_inc & ~w_dec) r_pend_total <= r_pend_total + 1'b1;
    else if (w_dec & ~w_inc) r_pend_total <= r_pend_total - 1'b1;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)      r_err <= 1'b0;
    else if (w_uflow) r_err <= 1'b1;
  end

  assign pend_total = r_pend_total;
  assign err        = r_err;

endmodule

// File: tb/tb_id_scoreboard.sv
// Bench for id_scoreboard: two instances (wb bypass on / off) driven by shared stimulus, checked against per-register count model.
module tb_id_scoreboard;

  logic        clk = 1'b0;
  logic        resetn;
  logic        issue_valid, issue_we, wb_valid, flush;
  logic [4:0]  issue_dest, wb_dest;
  logic [9:0]  issue_src;
  logic [1:0]  issue_src_used;

  logic        b1_rdy, b0_rdy, b1_err, b0_err;
  logic [31:0] b1_busy, b0_busy;
  logic [6:0]  b1_total, b0_total;

  int n_cmp = 0;
  int n_bad = 0;

  // Model: index 1 = bypass instance, index 0 = no-bypass instance.
  int m_cnt [2][32];
  bit m_err [2];
  bit last_rdy [2];

  always #5 clk = ~clk;

  id_scoreboard #(.REG_AW(5), .NUM_SRC(2), .CNT_W(2), .WB_BYPASS(1)) u_dut_byp (
    .clk(clk), .resetn(resetn), .issue_valid(issue_valid), .issue_ready(b1_rdy),
    .issue_we(issue_we), .issue_dest(issue_dest), .issue_src(issue_src),
    .issue_src_used(issue_src_used), .wb_valid(wb_valid), .wb_dest(wb_dest),
    .flush(flush), .busy_vec(b1_busy), .pend_total(b1_total), .err(b1_err)
  );

  id_scoreboard #(.REG_AW(5), .NUM_SRC(2), .CNT_W(2), .WB_BYPASS(0)) u_dut_nobyp (
    .clk(clk), .resetn(resetn), .issue_valid(issue_valid), .issue_ready(b0_rdy),
    .issue_we(issue_we), .issue_dest(issue_dest), .issue_src(issue_src),
    .issue_src_used(issue_src_used), .wb_valid(wb_valid), .wb_dest(wb_dest),
    .flush(flush), .busy_vec(b0_busy), .pend_total(b0_total), .err(b0_err)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic m_clear();
    for (int b = 0; b < 2; b++) begin
      for (int r = 0; r < 32; r++) m_cnt[b][r] = 0;
      m_err[b] = 1'b0;
    end
  endtask

  function automatic bit m_ready(input int b);
    bit haz = 1'b0;
    bit sat;
    int s, e;
    for (int i = 0; i < 2; i++) begin
      s = int'(issue_src[i*5 +: 5]);
      if (issue_src_used[i] && s != 0) begin
        e = m_cnt[b][s];
        if (b == 1 && wb_valid && int'(wb_dest) == s && e > 0) e = e - 1;
        if (e > 0) haz = 1'b1;
      end
    end
    sat = issue_we && issue_dest != 0 && m_cnt[b][issue_dest] == 3;
    return !flush && !haz && !sat;
  endfunction

  task automatic m_update(input int b, input bit fire);
    bit wb_nz;
    bit dec_ok;
    wb_nz  = wb_valid && wb_dest != 0;
    dec_ok = wb_nz && m_cnt[b][wb_dest] > 0;
    if (wb_nz && m_cnt[b][wb_dest] == 0) m_err[b] = 1'b1;
    if (flush) begin
      for (int r = 0; r < 32; r++) m_cnt[b][r] = 0;
    end else begin
      if (fire && issue_we && issue_dest != 0) m_cnt[b][issue_dest]++;
      if (dec_ok) m_cnt[b][wb_dest]--;
    end
  endtask

  task automatic check_state();
    logic [31:0] eb [2];
    int et [2];
    for (int b = 0; b < 2; b++) begin
      eb[b] = '0;
      et[b] = 0;
      for (int r = 1; r < 32; r++) begin
        eb[b][r] = (m_cnt[b][r] != 0);
        et[b] += m_cnt[b][r];
      end
    end
    check("busy_byp", b1_busy, eb[1]);
    check("total_byp", b1_total, et[1]);
    check("err_byp", b1_err, m_err[1]);
    check("busy_nobyp", b0_busy, eb[0]);
    check("total_nobyp", b0_total, et[0]);
    check("err_nobyp", b0_err, m_err[0]);
  endtask

  task automatic step(input bit v, input bit we, input int dest, input int s0, input int s1,
                      input logic [1:0] used, input bit wbv, input int wbd, input bit fl);
    bit er [2];
    @(negedge clk);
    issue_valid    = v;
    issue_we       = we;
    issue_dest     = 5'(dest);
    issue_src      = {5'(s1), 5'(s0)};
    issue_src_used = used;
    wb_valid       = wbv;
    wb_dest        = 5'(wbd);
    flush          = fl;
    #1;
    er[1] = m_ready(1);
    er[0] = m_ready(0);
    check("ready_byp", b1_rdy, er[1]);
    check("ready_nobyp", b0_rdy, er[0]);
    last_rdy[1] = b1_rdy;
    last_rdy[0] = b0_rdy;
    @(posedge clk);
    m_update(1, v && er[1]);
    m_update(0, v && er[0]);
    #1;
    check_state();
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 0, 2'b00, 0, 0, 0);
  endtask

  initial begin
    int q [$];
    bit v, we, wbv, fl;
    int dest, s0, s1, wbd;
    logic [1:0] used;

    resetn = 1'b0;
    issue_valid = 0; issue_we = 0; issue_dest = 0; issue_src = 0; issue_src_used = 0;
    wb_valid = 0; wb_dest = 0; flush = 0;
    m_clear();
    repeat (2) @(posedge clk);
    @(negedge clk);
    resetn = 1'b1;
    #1;
    check("rst_busy", b1_busy, 32'h0);
    check("rst_total", b1_total, 7'd0);
    check("rst_err", b1_err, 1'b0);
    check("rst_ready", b1_rdy, 1'b1);
    check("rst_ready_nobyp", b0_rdy, 1'b1);
    idle();

    // Load-use on r8, wb at cycle 4
    step(1, 1, 8, 0, 0, 2'b00, 0, 0, 0);
    check("lu_busy8", b1_busy[8], 1'b1);
    for (int c = 1; c <= 3; c++) begin
      step(1, 0, 0, 8, 0, 2'b01, 0, 0, 0);
      check("lu_stall_byp", last_rdy[1], 1'b0);
      check("lu_stall_nobyp", last_rdy[0], 1'b0);
    end
    step(1, 0, 0, 8, 0, 2'b01, 1, 8, 0);
    check("lu_c4_byp", last_rdy[1], 1'b1);
    check("lu_c4_nobyp", last_rdy[0], 1'b0);
    step(1, 0, 0, 8, 0, 2'b01, 0, 0, 0);
    check("lu_c5_nobyp", last_rdy[0], 1'b1);

    // Saturation on r3
    repeat (3) step(1, 1, 3, 0, 0, 2'b00, 0, 0, 0);
    check("sat_total", b1_total, 7'd3);
    step(1, 1, 3, 0, 0, 2'b00, 0, 0, 0);
    check("sat_stall", last_rdy[1], 1'b0);
    step(1, 1, 4, 0, 0, 2'b00, 0, 0, 0);
    check("sat_other_fires", last_rdy[1], 1'b1);
    step(1, 1, 3, 0, 0, 2'b00, 1, 3, 0);
    check("sat_no_credit", last_rdy[1], 1'b0);
    step(1, 1, 3, 0, 0, 2'b00, 0, 0, 0);
    check("sat_release", last_rdy[1], 1'b1);
    check("sat_total2", b1_total, 7'd4);

    // Simultaneous inc/dec on r6
    step(1, 1, 6, 0, 0, 2'b00, 0, 0, 0);
    check("sim_pre_total", b1_total, 7'd5);
    step(1, 1, 6, 0, 0, 2'b00, 1, 6, 0);
    check("sim_ready", last_rdy[1], 1'b1);
    check("sim_total", b1_total, 7'd5);
    check("sim_busy6", b1_busy[6], 1'b1);

    // r0 writes and unused sources
    step(1, 1, 0, 0, 0, 2'b00, 0, 0, 0);
    check("r0_total", b1_total, 7'd5);
    check("r0_busy", b1_busy[0], 1'b0);
    step(1, 1, 9, 0, 0, 2'b00, 0, 0, 0);
    step(1, 0, 0, 0, 9, 2'b01, 0, 0, 0);
    check("unused_src_fires", last_rdy[1], 1'b1);
    step(1, 0, 0, 0, 9, 2'b10, 0, 0, 0);
    check("used_src1_stalls", last_rdy[1], 1'b0);

    // Underflow then flush
    step(0, 0, 0, 0, 0, 2'b00, 1, 7, 0);
    check("uf_err", b1_err, 1'b1);
    step(0, 0, 0, 0, 0, 2'b00, 1, 9, 0);
    check("uf_err_sticky", b1_err, 1'b1);
    check("fl_pre_total", b1_total, 7'd5);
    step(1, 1, 12, 0, 0, 2'b00, 0, 0, 1);
    check("fl_ready", last_rdy[1], 1'b0);
    check("fl_total", b1_total, 7'd0);
    check("fl_err_kept", b1_err, 1'b1);

    // Asynchronous reset in the middle of a stall
    step(1, 1, 8, 0, 0, 2'b00, 0, 0, 0);
    @(negedge clk);
    issue_valid = 1; issue_we = 0; issue_src = {5'd0, 5'd8}; issue_src_used = 2'b01;
    #1;
    check("ar_pre_stall", b1_rdy, 1'b0);
    #2;
    resetn = 1'b0;
    #1;
    check("ar_busy", b1_busy, 32'h0);
    check("ar_total", b1_total, 7'd0);
    check("ar_err", b1_err, 1'b0);
    check("ar_ready", b1_rdy, 1'b1);
    m_clear();
    issue_valid = 0; issue_src_used = 2'b00;
    @(posedge clk);
    @(negedge clk);
    resetn = 1'b1;
    idle();

    // Randomised traffic
    for (int n = 0; n < 800; n++) begin
      v    = ($urandom_range(0, 3) != 0);
      we   = ($urandom_range(0, 3) != 0);
      dest = $urandom_range(0, 7);
      s0   = $urandom_range(0, 7);
      s1   = $urandom_range(0, 7);
      used = 2'($urandom_range(0, 3));
      fl   = ($urandom_range(0, 99) < 2);
      wbv  = 1'b0;
      wbd  = 0;
      q.delete();
      for (int r = 1; r < 32; r++) if (m_cnt[1][r] != 0) q.push_back(r);
      if (q.size() > 0 && $urandom_range(0, 99) < 45) begin
        wbv = 1'b1;
        wbd = q[$urandom_range(0, q.size() - 1)];
      end else if ($urandom_range(0, 99) < 3) begin
        wbv = 1'b1;
        wbd = $urandom_range(0, 31);
      end
      step(v, we, dest, s0, s1, used, wbv, wbd, fl);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
